// File: rtl/inst_encoder_if.sv
// Instruction-field input bus and encoded-word output bus of the RV32I encoder.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        addr_load;
  logic [31:0] addr_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    output addr_load, addr_val, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_sticky
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    input  addr_load, addr_val, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_sticky
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder with address tagging; immediate range check under RANGE_CHECK_EN.
// Latency: 1 cycle from accept to out_valid through a 2-entry output FIFO.
// Backpressure: in_ready = FIFO not full, driven only from the registered count.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (count < CW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  inst_encoder_if.slave bus
);
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  logic [31:0] enc_inst;
  logic [31:0] tag_addr;
  logic [31:0] addr_q;
  logic        word_err;
  logic        accept;
  logic        push_rdy;
  logic        pop_vld;
  ent_t        push_ent;
  ent_t        head_ent;

  always_comb begin
    enc_inst = 32'h0000_0013;
    unique case (bus.fmt)
      3'd0: enc_inst = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd1: enc_inst = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd2: enc_inst = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      3'd3: enc_inst = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], bus.opcode};
      3'd4: enc_inst = {bus.imm[31:12], bus.rd, bus.opcode};
      3'd5: enc_inst = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                        bus.rd, bus.opcode};
      default: enc_inst = 32'h0000_0013;
    endcase
  end

  assign accept   = bus.in_valid && push_rdy;
  assign tag_addr = bus.addr_load ? bus.addr_val : addr_q;

  // A load in the same cycle as an accept tags that word with the loaded address.
  always_ff @(posedge clk) begin
    if (rst)              addr_q <= BASE_ADDR;
    else if (accept)      addr_q <= tag_addr + 32'd4;
    else if (bus.addr_load) addr_q <= bus.addr_val;
  end

`ifdef RANGE_CHECK_EN
  logic range_err;
  logic sticky_q;

  always_comb begin
    range_err = 1'b0;
    unique case (bus.fmt)
      3'd0:       range_err = 1'b0;
      3'd1, 3'd2: range_err = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
      3'd3:       range_err = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
      3'd4:       range_err = (bus.imm[11:0] != 12'd0);
      3'd5:       range_err = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
      default:    range_err = 1'b1;
    endcase
  end

  assign word_err = range_err;

  always_ff @(posedge clk) begin
    if (rst)                      sticky_q <= 1'b0;
    else if (accept && word_err)  sticky_q <= 1'b1;
  end

  assign bus.err_sticky = sticky_q;
`else
  assign word_err       = 1'b0;
  assign bus.err_sticky = 1'b0;
`endif

  assign push_ent = '{inst: enc_inst, addr: tag_addr, err: word_err};

  fifo #(.W($bits(ent_t)), .DEPTH(2)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (bus.in_valid),
    .push_rdy (push_rdy),
    .push_dat (push_ent),
    .pop_vld  (pop_vld),
    .pop_rdy  (bus.out_ready),
    .pop_dat  (head_ent)
  );

  assign bus.in_ready  = push_rdy;
  assign bus.out_valid = pop_vld;
  assign bus.out_inst  = head_ent.inst;
  assign bus.out_addr  = head_ent.addr;
  assign bus.out_err   = head_ent.err;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors plus randomized traffic against a queue model.
module tb_inst_encoder;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_encoder_if bus ();

  inst_encoder #(.BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_addr;
  logic        mdl_sticky;
  int          n_tests = 0;
  int          n_fail  = 0;
`ifdef RANGE_CHECK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Field placement by shifting and masking the immediate as an integer.
  function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] regs;
    regs = (32'(f3) << 12) | (32'(rs1) << 15);
    w = 32'(op);
    case (f)
      3'd0: w = w | regs | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: w = w | regs | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
      3'd2: w = w | regs | ((imm & 32'h1F) << 7) | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
      3'd3: w = w | regs | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                | (32'(rs2) << 20) | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      3'd4: w = w | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
      3'd5: w = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  function automatic logic ref_bad(input logic [2:0] f, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (f)
      3'd0:       return 1'b0;
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3:       return (s < -4096) || (s > 4095) || (imm % 2 != 0);
      3'd4:       return (imm % 4096) != 0;
      3'd5:       return (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
      default:    return 1'b1;
    endcase
  endfunction

  task automatic set_word(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.fmt = f;  bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rd;  bus.rs1 = rs1;   bus.rs2 = rs2;   bus.imm = imm;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.addr_load = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    mdl_addr   = BASE;
    mdl_sticky = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic acc;
    logic pop;
    exp_t e;
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      check("out_inst", bus.out_inst, exp_q[0].inst);
      check("out_addr", bus.out_addr, exp_q[0].addr);
      check("out_err", 32'(bus.out_err), 32'(exp_q[0].err));
    end
    check("err_sticky", 32'(bus.err_sticky), 32'(mdl_sticky));
    acc = bus.in_valid && (exp_q.size() < 2);
    pop = (exp_q.size() != 0) && bus.out_ready;
    e.inst = ref_encode(bus.fmt, bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2, bus.imm);
    e.addr = bus.addr_load ? bus.addr_val : mdl_addr;
    e.err  = CHK_ON && ref_bad(bus.fmt, bus.imm);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(e);
        mdl_addr = e.addr + 32'd4;
        if (e.err) mdl_sticky = 1'b1;
      end else if (bus.addr_load) begin
        mdl_addr = bus.addr_val;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic exp_err;
    rst = 1'b1;
    idle();
    set_word(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid  = 1'b0;
    bus.addr_val  = 32'd0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_sticky", 32'(bus.err_sticky), 32'd0);

    // addi x1, x0, 5
    bus.out_ready = 1'b1;
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    step(); idle();
    check("addi_vld", 32'(bus.out_valid), 32'd1);
    check("addi_inst", bus.out_inst, 32'h0050_0093);
    check("addi_addr", bus.out_addr, 32'h0);
    step();

    // add then beq back-to-back
    do_reset();
    set_word(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    set_word(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    check("add_inst", bus.out_inst, 32'h0020_81B3);
    check("add_addr", bus.out_addr, 32'h0);
    step(); idle();
    check("beq_inst", bus.out_inst, 32'hFE20_8EE3);
    check("beq_addr", bus.out_addr, 32'h4);
    step();

    // jal with a simultaneous address load
    do_reset();
    set_word(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    bus.addr_load = 1'b1; bus.addr_val = 32'h100;
    step(); idle();
    check("jal_inst", bus.out_inst, 32'h0080_00EF);
    check("jal_addr", bus.out_addr, 32'h100);
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    step(); idle();
    check("after_jal_addr", bus.out_addr, 32'h104);
    step();

    // address counter wraps past 2^32
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7);
    bus.addr_load = 1'b1; bus.addr_val = 32'hFFFF_FFFC;
    step(); bus.addr_load = 1'b0;
    check("wrap_addr0", bus.out_addr, 32'hFFFF_FFFC);
    step(); idle();
    check("wrap_addr1", bus.out_addr, 32'h0);
    step();

    // backpressure: three words offered with the consumer stalled
    do_reset();
    bus.out_ready = 1'b0;
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    step();
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
    step();
    check("bp_full_rdy", 32'(bus.in_ready), 32'd0);
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    step();
    check("bp_stall_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    step();
    check("bp_drain1", bus.out_addr, 32'h4);
    step(); idle();
    check("bp_drain2", bus.out_addr, 32'h8);
    check("bp_drain2_inst", bus.out_inst, 32'h0030_0093);
    step();

    // out-of-range I immediate
    do_reset();
    exp_err = CHK_ON;
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    step(); idle();
    check("oor_inst", bus.out_inst, 32'h8000_0093);
    check("oor_err", 32'(bus.out_err), 32'(exp_err));
    check("oor_sticky", 32'(bus.err_sticky), 32'(exp_err));
    step(); step();

    // reset with two words queued
    do_reset();
    bus.out_ready = 1'b0;
    set_word(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step(); step(); idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    set_word(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    step(); idle();
    check("mid_rst_addr", bus.out_addr, BASE);
    step();

    // randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0, 1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:    imm = $urandom & 32'hFFFF_F000;
        default: imm = $urandom;
      endcase
      set_word(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), imm);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.addr_load = ($urandom_range(0, 19) == 0);
      bus.addr_val  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rst = ($urandom_range(0, 299) == 0);
      step();
      rst = 1'b0;
    end
    idle();
    bus.out_ready = 1'b1;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the first instruction-memory byte address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  instruction fields presented.
REQ-005 SHALL have port in_ready  output  1  encoder accepts fields this cycle.
REQ-006 SHALL have port fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7=invalid.
REQ-007 SHALL have ports opcode (input, 7), funct3 (input, 3) and funct7 (input, 7), each an instruction field.
REQ-008 SHALL have ports rd, rs1 and rs2, each input, 5 bits, register indices.
REQ-009 SHALL have port imm  input  32  signed immediate, full value, not pre-shifted.
REQ-010 SHALL have ports addr_load (input, 1) and addr_val (input, 32), used to load the next write address.
REQ-011 SHALL have port out_valid  output  1  encoded word available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the word.
REQ-013 SHALL have ports out_inst (output, 32, encoded RV32I word) and out_addr (output, 32, its byte address).
REQ-014 SHALL have ports out_err (output, 1, range violation on this word) and err_sticky (output, 1, any violation since reset).

Function
REQ-015 SHALL accept a word when in_valid && in_ready, and shall place it in a 2-entry FIFO holding {inst, addr, err}.
REQ-016 SHALL drive in_ready = (FIFO count < 2), registered; there is no combinational path from out_ready to in_ready.
REQ-017 SHALL assert out_valid exactly one cycle after a word is accepted into an empty FIFO; latency is 1 cycle.
REQ-018 SHALL pop the head word when out_valid && out_ready; a simultaneous push and pop leaves the count unchanged.
REQ-019 SHALL keep out_inst, out_addr and out_err stable while out_valid=1 and out_ready=0.
REQ-020 SHALL encode the R format as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-021 SHALL encode the I format as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-022 SHALL encode the S format as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-023 SHALL encode the B format as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-024 SHALL encode the U format as {imm[31:12], rd, opcode}.
REQ-025 SHALL encode the J format as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-026 SHALL encode an invalid fmt (6 or 7) as 32'h0000_0013 (NOP), and shall set out_err for it only when RANGE_CHECK_EN is defined.
REQ-027 SHALL keep an address counter, tag each accepted word with it, then add 4; the counter wraps modulo 2^32.
REQ-028 SHALL make addr_load=1 set the counter to addr_val; with a simultaneous accept, that word is tagged addr_val and the counter becomes addr_val+4.
REQ-029 SHALL not emit garbage words: an accept with in_ready=0 is ignored and the counter is unchanged.

Reset
REQ-030 SHALL on rst=1 at a clock edge clear the FIFO and set out_valid=0, in_ready=1, out_inst=0, out_addr=0, out_err=0, err_sticky=0 and counter=BASE_ADDR.
REQ-031 SHALL discard FIFO contents on a reset in mid-operation; rst has priority over push, pop and addr_load in the same cycle.

Configuration
REQ-032 SHALL implement immediate range checking when RANGE_CHECK_EN is defined, using these rules:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
REQ-033 SHALL, when a check fails, still emit the truncated encoding with out_err=1 and set err_sticky until reset.
REQ-034 SHALL, without RANGE_CHECK_EN, hold out_err and err_sticky at 0 and truncate silently.

Verification
REQ-035 SHALL cover I addi: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_valid=1, out_inst=0x00500093, out_addr=0x0.
REQ-036 SHALL cover R then B back-to-back:
  - R add: fmt=0, opcode=0x33, rd=3, rs1=1, rs2=2 -> out_inst=0x002081B3, out_addr=0x0.
  - B beq: opcode=0x63, rs1=1, rs2=2, imm=-4 -> out_inst=0xFE208EE3, out_addr=0x4.
REQ-037 SHALL cover J jal: fmt=5, opcode=0x6F, rd=1, imm=8 -> out_inst=0x008000EF; with addr_load=1, addr_val=0x100 in the same cycle -> out_addr=0x100, next word tagged 0x104.
REQ-038 SHALL cover backpressure: out_ready=0 while 3 words are offered -> in_ready=0 after 2 accepts; release out_ready -> words drain in order at addresses 0x0, 0x4, 0x8.
REQ-039 SHALL cover an out-of-range immediate: I, imm=2048, rd=1 -> out_inst=0x80000093; out_err=1 and err_sticky=1 with RANGE_CHECK_EN, both 0 without it.
REQ-040 SHALL cover reset with 2 words queued: rst=1 for one cycle -> out_valid=0, in_ready=1, next accepted word tagged BASE_ADDR.
